// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC,
// the NOP used while the ID stage has nothing valid, and the buffered entry type.
package fetch_stage_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [31:0]       RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0]       PC_INC           = 32'd4;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake bundle between fetch, instruction memory, execute (redirect) and ID.
// master = the fetch stage, slave = its environment.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              redirect;
  logic [31:0]       redirect_pc;

  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_inst;
  logic [31:0]       id_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output id_valid, id_inst, id_pc,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  id_valid, id_inst, id_pc,
    output id_ready
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small circular FIFO with a flush and an occupancy count; the head is read
// straight from the storage registers, so there is no push_data->head path.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop && count == CW'(DEPTH)));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order credit-limited requests
// to instruction memory, buffers {pc, inst} and squashes wrong-path work on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [31:0]   pc_q;
  logic [CW-1:0] drop_q;

  logic [CW-1:0] data_count;
  logic [CW-1:0] pcq_count;
  logic [CW-1:0] outstanding;
  logic [OW-1:0] occupancy;
  logic [EW-1:0] data_head_raw;
  fetch_entry_t  data_head;
  fetch_entry_t  resp_entry;
  logic [31:0]   pcq_head;

  logic grant;
  logic resp_keep;
  logic resp_drop;
  logic id_pop;
  logic data_push;

  // Every granted request is either waiting to be dropped or has a PC queued.
  assign outstanding = drop_q + pcq_count;

  // The ID pop this cycle frees a slot, which sustains one fetch per cycle.
  assign occupancy = OW'(outstanding) + OW'(data_count) - OW'(id_pop);

  assign bus.imem_req  = ~rst & ~bus.redirect & (occupancy < OW'(DEPTH));
  assign bus.imem_addr = pc_q;

  assign grant     = bus.imem_req & bus.imem_gnt;
  assign resp_keep = bus.imem_rvalid & (drop_q == '0);
  assign resp_drop = bus.imem_rvalid & (drop_q != '0);
  assign id_pop    = bus.id_valid & bus.id_ready;
  assign data_push = resp_keep & ~bus.redirect;

  assign resp_entry = '{pc: pcq_head, inst: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else if (bus.redirect) begin
      pc_q   <= word_align(bus.redirect_pc);
      // Everything still in flight after this cycle belongs to the old path.
      drop_q <= outstanding - CW'(bus.imem_rvalid);
    end else begin
      if (grant)     pc_q   <= pc_q + PC_INC;
      if (resp_drop) drop_q <= drop_q - CW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (grant),
    .push_data (pc_q),
    .pop       (resp_keep),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (data_push),
    .push_data (resp_entry),
    .pop       (id_pop),
    .head      (data_head_raw),
    .count     (data_count)
  );

  assign data_head = fetch_entry_t'(data_head_raw);

  assign bus.id_valid = (data_count != '0);
  assign bus.id_inst  = bus.id_valid ? data_head.inst : NOP_INST;
  assign bus.id_pc    = bus.id_valid ? data_head.pc   : RESET_PC;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: randomized memory/ID/redirect traffic with
// a program-order reference stream, plus directed reset/stall/redirect/wrap cases.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int cyc       = 0;
  int hs_cnt    = 0;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr   = RST_PC;
  int          tb_out     = 0;
  int          last_ready = 0;
  int          lat_min    = 1;
  int          lat_max    = 1;
  bit          gnt_rand   = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_pc;
  logic [31:0] stall_inst;

  // Instruction memory contents: word i holds the value i.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Program-order stream the ID stage must see from pc onward.
  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(pc + 32'(4 * i));
    exp_addr = pc;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: in-order responses, random latency >= 1 cycle.
  always @(posedge clk) begin
    #2;
    if (!rst && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    bus.imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    int r;
    if (rst) begin
      check_eq("req_in_reset", 32'(bus.imem_req), 32'd0);
      restart(RST_PC);
      tb_out     = 0;
      pend_q.delete();
      last_ready = cyc;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", 32'(bus.id_valid), 32'd1);
        check_eq("stall_pc", bus.id_pc, stall_pc);
        check_eq("stall_inst", bus.id_inst, stall_inst);
      end
      if (bus.id_valid && bus.id_ready) begin
        while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
        e = exp_q.pop_front();
        check_eq("id_pc", bus.id_pc, e);
        check_eq("id_inst", bus.id_inst, mem_word(e));
        hs_cnt++;
      end
      if (bus.imem_rvalid) tb_out--;
      if (bus.imem_req && bus.imem_gnt) begin
        check_eq("req_addr", bus.imem_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        r = cyc + $urandom_range(lat_min, lat_max);
        if (r <= last_ready) r = last_ready + 1;
        last_ready = r;
        pend_q.push_back('{addr: bus.imem_addr, ready: r});
        tb_out++;
        check_eq("credit_limit", 32'(tb_out <= DEPTH), 32'd1);
      end
      if (bus.redirect) begin
        check_eq("req_in_redirect", 32'(bus.imem_req), 32'd0);
        restart(bus.redirect_pc & ~32'h3);
      end
      stall_prev = bus.id_valid & ~bus.id_ready & ~bus.redirect;
      stall_pc   = bus.id_pc;
      stall_inst = bus.id_inst;
    end
  end

  task automatic wait_first_valid(input string name, input logic [31:0] exp);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.id_valid) begin
        check_eq(name, bus.id_pc, exp);
        found = 1'b1;
        break;
      end
    end
    check_eq({name, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
    check_eq({tag, "_id_inst"}, bus.id_inst, NOP_INST);
    check_eq({tag, "_id_pc"}, bus.id_pc, RST_PC);
    check_eq({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
  endtask

  initial begin
    int h0;
    bit ok;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready    = 1'b1;
    restart(RST_PC);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // Grant in the first cycle out of reset, response next cycle, ID valid the one after.
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("lat_cycle0_valid", 32'(bus.id_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_cycle1_valid", 32'(bus.id_valid), 32'd0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", 32'(bus.id_valid), 32'd1);
    check_eq("lat_cycle2_pc", bus.id_pc, RST_PC);
    @(posedge clk);
    h0 = hs_cnt;
    repeat (8) @(posedge clk);
    check_eq("throughput", 32'(hs_cnt - h0), 32'd8);

    // ID back-pressure: fetch must stop once DEPTH entries are in flight or buffered.
    #1 bus.id_ready = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("stall_req_low", 32'(bus.imem_req), 32'd0);
    check_eq("stall_holds_valid", 32'(bus.id_valid), 32'd1);
    @(posedge clk);
    #1 bus.id_ready = 1'b1;
    repeat (6) @(posedge clk);

    // Redirect with two requests outstanding; both responses must be squashed.
    lat_min = 3;
    lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (tb_out == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("two_outstanding_reached", 32'(ok), 32'd1);
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    wait_first_valid("redirect_target", 32'h0000_0100);
    lat_min = 1;
    lat_max = 1;
    repeat (10) @(posedge clk);

    // Redirect in a cycle that also carries a response and an ID handshake.
    #1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(negedge clk);
    check_eq("coincident_rvalid", 32'(bus.imem_rvalid), 32'd1);
    check_eq("coincident_id_valid", 32'(bus.id_valid), 32'd1);
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    wait_first_valid("coincident_target", 32'h0000_0200);
    repeat (6) @(posedge clk);

    // Sequential fetch across the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    wait_first_valid("wrap_start", 32'hFFFF_FFF8);
    h0 = hs_cnt;
    repeat (6) @(posedge clk);
    check_eq("wrap_progress", 32'(hs_cnt - h0 >= 4), 32'd1);

    // Reset with the FIFO full.
    #1 bus.id_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.id_ready = 1'b1;
    wait_first_valid("resume_after_reset", RST_PC);

    // Randomized traffic.
    gnt_rand = 1'b1;
    lat_min  = 1;
    lat_max  = 4;
    h0 = hs_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      bus.id_ready = ($urandom_range(0, 3) != 0);
      bus.redirect = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) bus.redirect_pc = 32'hFFFF_FF00 | ($urandom & 32'h0000_00FF);
      else                           bus.redirect_pc = $urandom & 32'h0000_3FFF;
      rst = ($urandom_range(0, 599) == 0);
    end
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    repeat (20) @(posedge clk);
    check_eq("random_progress", 32'(hs_cnt - h0 > 300), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
